// File: rtl/input_debounce.sv
`timescale 1ns/1ps
// Nine-channel pad debouncer with a 2-flop synchronizer, a per-bit stability counter and sticky press-event flags.
// Latency: 2 + DEBOUNCE_COUNT clk cycles from a raw_in change to state_out, with the input held stable.
// Backpressure: none; event_clear is a write-1-to-clear strobe sampled every cycle. Events exist only with ATARI_INPUT_EVENT_EN.
module input_debounce #(
    parameter int DEBOUNCE_COUNT = 27000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] raw_in,
    output logic [8:0] state_out,
    output logic [8:0] event_out,
    input  logic [8:0] event_clear,
    output logic       any_event
);

    // Terminal count: a change is accepted on the edge where the counter already shows DEBOUNCE_COUNT-1.
    localparam logic [15:0] LAST = 16'(DEBOUNCE_COUNT - 1);

    logic [8:0]  sync_meta;
    logic [8:0]  sync_raw;
    logic [8:0]  sync_pressed;
    logic [8:0]  state_nxt;
    logic [15:0] cnt     [0:8];
    logic [15:0] cnt_nxt [0:8];

    // Pads are active-low; synchronizer flops rest at 1 (released).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '1;
            sync_raw  <= '1;
        end else begin
            sync_meta <= raw_in;
            sync_raw  <= sync_meta;
        end
    end

    assign sync_pressed = ~sync_raw;

    // Per-bit stability counting: any agreement with state_out restarts the count, so glitches are discarded.
    always_comb begin
        state_nxt = state_out;
        for (int i = 0; i < 9; i++) begin
            cnt_nxt[i] = '0;
            if (sync_pressed[i] != state_out[i]) begin
                if (cnt[i] == LAST) begin
                    state_nxt[i] = sync_pressed[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 16'd1;
                end
            end
        end
    end

    // Counter and debounced state registers; reset discards any partial count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 9; i++) begin
                cnt[i] <= '0;
            end
            state_out <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            state_out <= state_nxt;
        end
    end

`ifdef ATARI_INPUT_EVENT_EN
    logic [8:0] press_rise;

    assign press_rise = state_nxt & ~state_out;

    // Sticky press flags: a new press wins over a coincident clear; releases never set a flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_out <= '0;
        end else begin
            event_out <= (event_out & ~event_clear) | press_rise;
        end
    end

    assign any_event = |event_out;
`else
    // Event logic compiled out: outputs tied low and the clear strobe is ignored.
    logic unused_event_clear;

    assign unused_event_clear = ^event_clear;
    assign event_out          = '0;
    assign any_event          = 1'b0;
`endif

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL provide parameter DEBOUNCE_COUNT, default 27000 (1 ms at 27 MHz), the number of consecutive stable clk cycles required to accept a change; legal range 2..65535.
REQ-002 SHALL provide port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port raw_in, input, 9, asynchronous active-low pad inputs with this mapping:
- bits [4:0]: joystick_0..joystick_4
- bit 5: button_reset
- bit 6: button_halt
- bit 7: button_select
- bit 8: button_0
REQ-005 SHALL provide port state_out, output, 9, the debounced pressed state (1 = pressed, same bit mapping as raw_in).
REQ-006 SHALL provide port event_out, output, 9, sticky press-event flags.
REQ-007 SHALL provide port event_clear, input, 9, write-1-to-clear strobe for event_out, sampled every cycle.
REQ-008 SHALL provide port any_event, output, 1, the OR of event_out.

Function
REQ-009 Each raw_in bit SHALL pass through a two-flip-flop synchronizer and then be inverted to form sync_pressed.
REQ-010 Each bit SHALL have an independent 16-bit stability counter.
REQ-011 Per-bit counter and state behaviour SHALL be:
- sync_pressed == state_out: counter cleared to 0.
- sync_pressed != state_out and counter < DEBOUNCE_COUNT-1: counter increments.
- sync_pressed != state_out and counter == DEBOUNCE_COUNT-1: state_out bit takes sync_pressed on that edge and the counter clears to 0.
REQ-012 Latency SHALL be exactly 2 + DEBOUNCE_COUNT clk cycles from a sampled raw_in change to the state_out update, provided the input stays stable throughout.
REQ-013 A glitch shorter than DEBOUNCE_COUNT cycles at sync_pressed SHALL NOT change state_out and SHALL clear that bit's counter.
REQ-014 Press and release SHALL be debounced symmetrically.
REQ-015 Counters SHALL never wrap; no counter exceeds DEBOUNCE_COUNT-1.
REQ-016 A 0->1 transition of a state_out bit SHALL set the matching event_out bit on the same edge; a 1->0 transition SHALL NOT set it.
REQ-017 An event_clear bit of 1 SHALL clear the matching event_out bit on the next edge.
REQ-018 When set and clear coincide on the same bit, set SHALL win and the bit SHALL remain 1.
REQ-019 An event_out bit already at 1 SHALL stay 1 on a further press; events are not counted.
REQ-020 any_event SHALL be combinational from the registered event_out.
REQ-021 All nine bits SHALL operate independently, and simultaneous changes SHALL be handled in parallel.

Reset
REQ-022 On reset_n low, independent of clk, the block SHALL force:
- synchronizer flops to 1 (released),
- counters to 0,
- state_out to 0,
- event_out to 0 (so any_event is 0).
REQ-023 Reset deassertion while a button is held SHALL produce a press only after the full 2 + DEBOUNCE_COUNT cycles, and that press SHALL set the event bit.
REQ-024 Reset asserted mid-count SHALL discard the partial count.

Configuration
REQ-025 With macro ATARI_INPUT_EVENT_EN defined, event_out, event_clear and any_event SHALL behave per REQ-016..REQ-020.
REQ-026 With ATARI_INPUT_EVENT_EN undefined:
- event_out SHALL be tied to 0 and any_event SHALL be tied to 0.
- event_clear SHALL be ignored.
- no event registers SHALL be synthesized.
- debounce behaviour SHALL be unchanged.

Verification (DEBOUNCE_COUNT=4, ATARI_INPUT_EVENT_EN defined unless stated)
REQ-027 Stable press: raw_in[0] 1->0 and held -> state_out[0]=1 exactly 6 cycles later, event_out=9'h001, any_event=1.
REQ-028 Glitch: raw_in[6] low for 3 cycles, then high -> state_out and event_out remain 0 throughout.
REQ-029 Clear race: event_out[8]=1 and event_clear=9'h100 pulsed on the edge where a new press of bit 8 sets -> event_out[8] stays 1; a later pulse with no press -> 0.
REQ-030 Release: held bit 3 released -> state_out[3]=0 after 6 cycles, event_out[3] unchanged.
REQ-031 Reset mid-count: reset_n pulsed low 2 cycles into a press of bit 5 -> all outputs 0 immediately; press recognized 6 cycles after reset release.
REQ-032 Macro off: repeat the REQ-027 stimulus -> state_out[0]=1 after 6 cycles, event_out=0, any_event=0.
